// File: rtl/dataflow_pkg.sv
// Shared defaults and width-generic arithmetic helpers for the dataflow pipeline.
// Helpers work on a MAX_W container; callers pass the live width and truncate the result.
package dataflow_pkg;

    localparam int unsigned MAX_W        = 32;
    localparam int unsigned DEF_WIDTH    = 8;
    localparam int unsigned DEF_INC      = 1;
    localparam int unsigned DEF_THRESH   = 16;
    localparam int unsigned DEF_SHIFT    = 1;
    localparam int unsigned DEF_SATURATE = 0;
    localparam int unsigned DEF_CNT_W    = 16;

    typedef logic [MAX_W-1:0] word_t;

    function automatic word_t width_mask(input int unsigned w);
        word_t ones;
        ones = '1;
        return (w >= MAX_W) ? ones : ~(ones << w);
    endfunction

    // Overflow is any carry out of bit w-1; saturation clamps to all-ones of width w.
    function automatic word_t df_add(input word_t a, input word_t inc,
                                     input logic sat, input int unsigned w);
        word_t          mask;
        logic [MAX_W:0] sum;
        mask = width_mask(w);
        sum  = {1'b0, a & mask} + {1'b0, inc & mask};
        if (sat && ((sum >> w) != '0)) return mask;
        return sum[MAX_W-1:0] & mask;
    endfunction

    function automatic word_t df_shl(input word_t a, input int unsigned sh,
                                     input logic sat, input int unsigned w);
        word_t              mask;
        logic [2*MAX_W-1:0] full;
        mask = width_mask(w);
        full = {{MAX_W{1'b0}}, a & mask} << sh;
        if (sat && ((full >> w) != '0)) return mask;
        return full[MAX_W-1:0] & mask;
    endfunction

endpackage

// File: rtl/dataflow_pipe_param_if.sv
// Streaming bus of the dataflow pipeline: input/output handshakes, flush and the
// completed-transaction counter.
interface dataflow_pipe_param_if
    import dataflow_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned CNT_W = DEF_CNT_W
);
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_scaled;
    logic [CNT_W-1:0] out_count;

    modport master (
        output flush, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_scaled, out_count
    );

    modport slave (
        input  flush, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_scaled, out_count
    );
endinterface

// File: rtl/dataflow_stage_reg.sv
// One valid/ready register slice: loads whenever empty or its successor drains it.
// No skid buffer, so ready_o is a combinational function of ready_i.
module dataflow_stage_reg #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush_i,
    input  logic         valid_i,
    input  logic [W-1:0] data_i,
    output logic         ready_o,
    output logic         valid_o,
    output logic [W-1:0] data_o,
    input  logic         ready_i
);
    logic         valid_q;
    logic [W-1:0] data_q;

    assign ready_o = !valid_q || ready_i;
    assign valid_o = valid_q;
    assign data_o  = data_q;

    // NOTE: sequential state uses non-blocking assignments so every slice samples
    // its neighbour's pre-edge value; blocking here would collapse stages together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            if (flush_i)      valid_q <= 1'b0;
            else if (ready_o) valid_q <= valid_i;
            // NOTE: only loaded on a real transfer, so a stalled slice holds its data.
            if (ready_o && valid_i) data_q <= data_i;
        end
    end
endmodule

// File: rtl/dataflow_pipe_param.sv
// 3-stage dataflow pipeline: capture -> increment/threshold -> conditional shift,
// with valid/ready backpressure, synchronous flush and an output handshake counter.
module dataflow_pipe_param
    import dataflow_pkg::*;
#(
    parameter int unsigned WIDTH    = DEF_WIDTH,
    parameter int unsigned INC      = DEF_INC,
    parameter int unsigned THRESH   = DEF_THRESH,
    parameter int unsigned SHIFT    = DEF_SHIFT,
    parameter int unsigned SATURATE = DEF_SATURATE,
    parameter int unsigned CNT_W    = DEF_CNT_W
) (
    input logic                  clk,
    input logic                  rst,
    dataflow_pipe_param_if.slave bus
);
    localparam logic SAT = (SATURATE != 0);

    logic             ready1, ready2, ready3;
    logic             v1, v2, v3;
    logic [WIDTH-1:0] d1, d2;
    logic             sc2;
    logic [WIDTH-1:0] s2_sum, s3_shl;
    logic             s2_scale;
    logic [WIDTH:0]   s2_in, s2_out, s3_in, s3_out;
    logic [CNT_W-1:0] count_q, count_d;

    dataflow_stage_reg #(.W(WIDTH)) u_s1 (
        .clk     (clk),
        .rst     (rst),
        .flush_i (bus.flush),
        .valid_i (bus.in_valid),
        .data_i  (bus.in_data),
        .ready_o (ready1),
        .valid_o (v1),
        .data_o  (d1),
        .ready_i (ready2)
    );

    // Threshold uses the pre-increment value held in stage 1.
    assign s2_scale = word_t'(d1) > word_t'(THRESH);
    assign s2_sum   = WIDTH'(df_add(word_t'(d1), word_t'(INC), SAT, WIDTH));
    assign s2_in    = {s2_scale, s2_sum};

    dataflow_stage_reg #(.W(WIDTH + 1)) u_s2 (
        .clk     (clk),
        .rst     (rst),
        .flush_i (bus.flush),
        .valid_i (v1),
        .data_i  (s2_in),
        .ready_o (ready2),
        .valid_o (v2),
        .data_o  (s2_out),
        .ready_i (ready3)
    );

    assign sc2    = s2_out[WIDTH];
    assign d2     = s2_out[WIDTH-1:0];
    assign s3_shl = WIDTH'(df_shl(word_t'(d2), SHIFT, SAT, WIDTH));
    assign s3_in  = {sc2, (sc2 ? s3_shl : d2)};

    dataflow_stage_reg #(.W(WIDTH + 1)) u_s3 (
        .clk     (clk),
        .rst     (rst),
        .flush_i (bus.flush),
        .valid_i (v2),
        .data_i  (s3_in),
        .ready_o (ready3),
        .valid_o (v3),
        .data_o  (s3_out),
        .ready_i (bus.out_ready)
    );

    // Flush wins over any transfer, so nothing is accepted in the flush cycle.
    assign bus.in_ready   = ready1 && !bus.flush;
    assign bus.out_valid  = v3;
    assign bus.out_data   = s3_out[WIDTH-1:0];
    assign bus.out_scaled = s3_out[WIDTH];
    assign bus.out_count  = count_q;

    // NOTE: next-state logic assigns its default first so no path can infer a latch.
    always_comb begin
        count_d = count_q;
        if (v3 && bus.out_ready) count_d = count_q + CNT_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) count_q <= '0;
        else     count_q <= count_d;
    end
endmodule

// File: tb/tb_dataflow_pipe_param.sv
// Scoreboard bench: two 8-bit instances (wrap, saturate) share stimulus; a 16-bit
// instance runs the same scenarios. Expected results are hand-computed constants.
module tb_dataflow_pipe_param;

    typedef struct {
        logic [15:0] data;
        logic        scaled;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        flush8 = 1'b0, in_valid8 = 1'b0, out_ready8 = 1'b1;
    logic [7:0]  in_data8 = '0;
    logic        flush16 = 1'b0, in_valid16 = 1'b0, out_ready16 = 1'b1;
    logic [15:0] in_data16 = '0;

    exp_t qa[$], qb[$], qc[$];
    exp_t ea, eb, ec;
    int   n_checks = 0;
    int   n_fail   = 0;
    logic [15:0] base_a, base_b, base_c;
    logic [15:0] hold;

    dataflow_pipe_param_if #(.WIDTH(8),  .CNT_W(16)) ia ();
    dataflow_pipe_param_if #(.WIDTH(8),  .CNT_W(16)) ib ();
    dataflow_pipe_param_if #(.WIDTH(16), .CNT_W(16)) ic ();

    assign ia.flush = flush8;   assign ia.in_valid = in_valid8;
    assign ia.in_data = in_data8; assign ia.out_ready = out_ready8;
    assign ib.flush = flush8;   assign ib.in_valid = in_valid8;
    assign ib.in_data = in_data8; assign ib.out_ready = out_ready8;
    assign ic.flush = flush16;  assign ic.in_valid = in_valid16;
    assign ic.in_data = in_data16; assign ic.out_ready = out_ready16;

    dataflow_pipe_param #(.WIDTH(8), .INC(1), .THRESH(16), .SHIFT(1), .SATURATE(0), .CNT_W(16))
        dut_a (.clk(clk), .rst(rst), .bus(ia));
    dataflow_pipe_param #(.WIDTH(8), .INC(1), .THRESH(16), .SHIFT(1), .SATURATE(1), .CNT_W(16))
        dut_b (.clk(clk), .rst(rst), .bus(ib));
    dataflow_pipe_param #(.WIDTH(16), .INC(3), .THRESH(1000), .SHIFT(4), .SATURATE(0), .CNT_W(16))
        dut_c (.clk(clk), .rst(rst), .bus(ic));

    // Directed vectors: input, expected wrap result, expected saturate result, scaled flag.
    logic [7:0]  v8_in  [0:6] = '{8'h10, 8'h11, 8'h05, 8'h90, 8'hFF, 8'h7F, 8'h20};
    logic [7:0]  v8_wr  [0:6] = '{8'h11, 8'h24, 8'h06, 8'h22, 8'h00, 8'h00, 8'h42};
    logic [7:0]  v8_sat [0:6] = '{8'h11, 8'h24, 8'h06, 8'hFF, 8'hFF, 8'hFF, 8'h42};
    logic        v8_sc  [0:6] = '{1'b0,  1'b1,  1'b0,  1'b1,  1'b1,  1'b1,  1'b1};
    logic [15:0] v16_in [0:5] = '{16'h0020, 16'h03E8, 16'h03E9, 16'hFFFF, 16'h1234, 16'h0FFD};
    logic [15:0] v16_ex [0:5] = '{16'h0023, 16'h03EB, 16'h3EC0, 16'h0020, 16'h2370, 16'h0000};
    logic        v16_sc [0:5] = '{1'b0,     1'b0,     1'b1,     1'b1,     1'b1,     1'b1};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitors: pop one expectation per output handshake.
    always @(negedge clk) begin
        if (!rst && ia.out_valid && ia.out_ready) begin
            check("a_expected_pending", 32'(qa.size() != 0), 1);
            if (qa.size() != 0) begin
                ea = qa.pop_front();
                check("a_out_data", 32'(ia.out_data), 32'(ea.data));
                check("a_out_scaled", 32'(ia.out_scaled), 32'(ea.scaled));
            end
        end
        if (!rst && ib.out_valid && ib.out_ready) begin
            check("b_expected_pending", 32'(qb.size() != 0), 1);
            if (qb.size() != 0) begin
                eb = qb.pop_front();
                check("b_out_data", 32'(ib.out_data), 32'(eb.data));
                check("b_out_scaled", 32'(ib.out_scaled), 32'(eb.scaled));
            end
        end
        if (!rst && ic.out_valid && ic.out_ready) begin
            check("c_expected_pending", 32'(qc.size() != 0), 1);
            if (qc.size() != 0) begin
                ec = qc.pop_front();
                check("c_out_data", 32'(ic.out_data), 32'(ec.data));
                check("c_out_scaled", 32'(ic.out_scaled), 32'(ec.scaled));
            end
        end
    end

    task automatic send8(input logic [7:0] d, input logic [7:0] xa, input logic [7:0] xb,
                         input logic sc, input bit push);
        int   n = 0;
        exp_t e;
        if (push) begin
            e.scaled = sc;
            e.data = 16'(xa); qa.push_back(e);
            e.data = 16'(xb); qb.push_back(e);
        end
        in_valid8 = 1'b1;
        in_data8  = d;
        @(negedge clk);
        while (!ia.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("a_input_accepted", 32'(ia.in_ready), 1);
        @(posedge clk); #1;
        in_valid8 = 1'b0;
    endtask

    task automatic send16(input logic [15:0] d, input logic [15:0] x, input logic sc,
                          input bit push);
        int   n = 0;
        exp_t e;
        if (push) begin
            e.data = x; e.scaled = sc; qc.push_back(e);
        end
        in_valid16 = 1'b1;
        in_data16  = d;
        @(negedge clk);
        while (!ic.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("c_input_accepted", 32'(ic.in_ready), 1);
        @(posedge clk); #1;
        in_valid16 = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((qa.size() + qb.size() + qc.size()) != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("drain_all_outputs_seen", 32'(qa.size() + qb.size() + qc.size()), 0);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_a_out_valid", 32'(ia.out_valid), 0);
        check("rst_a_out_data",  32'(ia.out_data), 0);
        check("rst_a_out_count", 32'(ia.out_count), 0);
        check("rst_a_in_ready",  32'(ia.in_ready), 1);
        check("rst_c_out_valid", 32'(ic.out_valid), 0);
        check("rst_c_out_data",  32'(ic.out_data), 0);
        @(posedge clk); #1;

        // Single-item latency, 8-bit.
        send8(8'h20, 8'h42, 8'h42, 1'b1, 1'b1);
        @(negedge clk); check("a_latency_c1", 32'(ia.out_valid), 0);
        @(negedge clk); check("a_latency_c2", 32'(ia.out_valid), 0);
        @(negedge clk); check("a_latency_c3", 32'(ia.out_valid), 1);
        drain();

        // Threshold boundary and wrap/saturate vectors, issued back to back.
        for (int i = 0; i < 7; i++) send8(v8_in[i], v8_wr[i], v8_sat[i], v8_sc[i], 1'b1);
        drain();

        // Backpressure: 5-cycle consumer stall mid-stream.
        base_a = ia.out_count;
        base_b = ib.out_count;
        fork
            for (int i = 1; i <= 10; i++) send8(8'(i), 8'(i + 1), 8'(i + 1), 1'b0, 1'b1);
            begin
                repeat (4) @(posedge clk);
                #1 out_ready8 = 1'b0;
                @(negedge clk);
                check("a_stall_out_valid", 32'(ia.out_valid), 1);
                hold = 16'(ia.out_data);
                repeat (4) @(negedge clk);
                check("a_stall_in_ready_low", 32'(ia.in_ready), 0);
                check("a_stall_data_held", 32'(ia.out_data), 32'(hold));
                @(posedge clk); #1 out_ready8 = 1'b1;
                @(negedge clk);
                check("a_in_ready_follows_out_ready", 32'(ia.in_ready), 1);
            end
        join
        drain();
        check("a_bp_count", 32'(16'(ia.out_count - base_a)), 10);
        check("b_bp_count", 32'(16'(ib.out_count - base_b)), 10);

        // Flush with three items in flight; those items are never expected.
        out_ready8 = 1'b0;
        base_a = ia.out_count;
        for (int i = 1; i <= 3; i++) send8(8'(i), 8'h00, 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        check("a_full_in_ready", 32'(ia.in_ready), 0);
        check("a_full_out_valid", 32'(ia.out_valid), 1);
        @(posedge clk); #1;
        flush8 = 1'b1; in_valid8 = 1'b1; in_data8 = 8'h33;
        @(negedge clk);
        check("a_flush_in_ready", 32'(ia.in_ready), 0);
        @(posedge clk); #1;
        flush8 = 1'b0; in_valid8 = 1'b0;
        @(negedge clk);
        check("a_flush_out_valid", 32'(ia.out_valid), 0);
        check("b_flush_out_valid", 32'(ib.out_valid), 0);
        check("a_flush_count_kept", 32'(ia.out_count), 32'(base_a));
        out_ready8 = 1'b1;
        repeat (4) @(negedge clk);
        check("a_flush_no_stale", 32'(ia.out_valid), 0);
        @(posedge clk); #1;
        send8(8'h05, 8'h06, 8'h06, 1'b0, 1'b1);
        drain();

        // Asynchronous reset in the middle of a stream.
        for (int i = 0; i < 5; i++) send8(8'h07, 8'h08, 8'h08, 1'b0, 1'b1);
        in_valid8 = 1'b1; in_data8 = 8'h07;
        repeat (3) @(posedge clk);
        #3;
        check("a_count_before_rst_nonzero", 32'(ia.out_count != 0), 1);
        rst = 1'b1;
        #1;
        check("a_async_rst_out_valid", 32'(ia.out_valid), 0);
        check("a_async_rst_out_data",  32'(ia.out_data), 0);
        check("a_async_rst_out_count", 32'(ia.out_count), 0);
        check("b_async_rst_out_count", 32'(ib.out_count), 0);
        qa.delete(); qb.delete();
        in_valid8 = 1'b0;
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); #1;
        send8(8'h20, 8'h42, 8'h42, 1'b1, 1'b1);
        drain();

        // 16-bit configuration: INC=3, THRESH=1000, SHIFT=4.
        send16(16'h0020, 16'h0023, 1'b0, 1'b1);
        @(negedge clk); check("c_latency_c1", 32'(ic.out_valid), 0);
        @(negedge clk); check("c_latency_c2", 32'(ic.out_valid), 0);
        @(negedge clk); check("c_latency_c3", 32'(ic.out_valid), 1);
        drain();
        for (int i = 0; i < 6; i++) send16(v16_in[i], v16_ex[i], v16_sc[i], 1'b1);
        drain();

        base_c = ic.out_count;
        fork
            for (int i = 1; i <= 10; i++) send16(16'(i), 16'(i + 3), 1'b0, 1'b1);
            begin
                repeat (4) @(posedge clk);
                #1 out_ready16 = 1'b0;
                @(negedge clk);
                check("c_stall_out_valid", 32'(ic.out_valid), 1);
                hold = ic.out_data;
                repeat (4) @(negedge clk);
                check("c_stall_in_ready_low", 32'(ic.in_ready), 0);
                check("c_stall_data_held", 32'(ic.out_data), 32'(hold));
                @(posedge clk); #1 out_ready16 = 1'b1;
            end
        join
        drain();
        check("c_bp_count", 32'(16'(ic.out_count - base_c)), 10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
